// File: rtl/risc_mgmt_decode_arbiter.sv
// Broadcasts decode-stage instructions to N_EXT extensions, picks the lowest-index
// enabled claimant and registers its decode fields into a valid/ready output stage.
module risc_mgmt_decode_arbiter #(
    parameter int N_EXT  = 4,
    parameter int SEL_W  = 5,
    parameter int INSN_W = 32,
    parameter int CNT_W  = 8,
    parameter int ID_W   = (N_EXT > 1) ? $clog2(N_EXT) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     insn_valid,
    input  logic [INSN_W-1:0]        insn,
    output logic                     insn_ready,
    input  logic [N_EXT-1:0]         ext_enable,
    output logic [INSN_W-1:0]        ext_insn,
    input  logic [N_EXT-1:0]         ext_claim,
    input  logic [N_EXT-1:0]         ext_mem_to_reg,
    input  logic [N_EXT*SEL_W-1:0]   ext_rsel_s_0,
    input  logic [N_EXT*SEL_W-1:0]   ext_rsel_s_1,
    input  logic [N_EXT*SEL_W-1:0]   ext_rsel_d,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_claim,
    output logic [ID_W-1:0]          out_ext_id,
    output logic                     out_mem_to_reg,
    output logic [SEL_W-1:0]         out_rsel_s_0,
    output logic [SEL_W-1:0]         out_rsel_s_1,
    output logic [SEL_W-1:0]         out_rsel_d,
    output logic [INSN_W-1:0]        out_insn,
    output logic                     conflict,
    output logic [CNT_W-1:0]         conflict_count,
    input  logic                     clear_conflict
);

    localparam logic [N_EXT-1:0] EFF_ONE = N_EXT'(1);

    logic [N_EXT-1:0] eff;
    logic [SEL_W-1:0] rs0_arr [N_EXT];
    logic [SEL_W-1:0] rs1_arr [N_EXT];
    logic [SEL_W-1:0] rd_arr  [N_EXT];

    logic             accept;
    logic             multi_claim;
    logic             conflict_event;
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic             win_m2r;
    logic [SEL_W-1:0] win_s0;
    logic [SEL_W-1:0] win_s1;
    logic [SEL_W-1:0] win_d;

    logic              out_valid_reg;
    logic              out_claim_reg;
    logic [ID_W-1:0]   out_ext_id_reg;
    logic              out_m2r_reg;
    logic [SEL_W-1:0]  out_s0_reg;
    logic [SEL_W-1:0]  out_s1_reg;
    logic [SEL_W-1:0]  out_d_reg;
    logic [INSN_W-1:0] out_insn_reg;
    logic              conflict_reg;
    logic [CNT_W-1:0]  conflict_count_reg;
    logic [CNT_W-1:0]  conflict_count_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_EXT; gi++) begin : g_unpack
            assign rs0_arr[gi] = ext_rsel_s_0[gi*SEL_W +: SEL_W];
            assign rs1_arr[gi] = ext_rsel_s_1[gi*SEL_W +: SEL_W];
            assign rd_arr[gi]  = ext_rsel_d[gi*SEL_W +: SEL_W];
        end
    endgenerate

    assign ext_insn   = insn;
    assign insn_ready = !out_valid_reg || out_ready;
    assign accept     = insn_valid && insn_ready;
    assign eff        = ext_claim & ext_enable;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign multi_claim    = |(eff & (eff - EFF_ONE));
    assign conflict_event = accept && multi_claim;

    // Scanning downward lets the lowest-index claimant overwrite higher ones.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_m2r   = 1'b0;
        win_s0    = '0;
        win_s1    = '0;
        win_d     = '0;
        for (int i = N_EXT - 1; i >= 0; i--) begin
            if (eff[i]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
                win_m2r   = ext_mem_to_reg[i];
                win_s0    = rs0_arr[i];
                win_s1    = rs1_arr[i];
                win_d     = rd_arr[i];
            end
        end
    end

    always_comb begin
        conflict_count_next = conflict_count_reg;
        if (clear_conflict) begin
            conflict_count_next = conflict_event ? CNT_W'(1) : '0;
        end else if (conflict_event && (conflict_count_reg != {CNT_W{1'b1}})) begin
            conflict_count_next = conflict_count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_reg      <= 1'b0;
            out_claim_reg      <= 1'b0;
            out_ext_id_reg     <= '0;
            out_m2r_reg        <= 1'b0;
            out_s0_reg         <= '0;
            out_s1_reg         <= '0;
            out_d_reg          <= '0;
            out_insn_reg       <= '0;
            conflict_reg       <= 1'b0;
            conflict_count_reg <= '0;
        end else begin
            if (accept) begin
                out_valid_reg  <= 1'b1;
                out_insn_reg   <= insn;
                out_claim_reg  <= win_found;
                out_ext_id_reg <= win_id;
                out_m2r_reg    <= win_m2r;
                out_s0_reg     <= win_s0;
                out_s1_reg     <= win_s1;
                out_d_reg      <= win_d;
            end else if (out_ready) begin
                out_valid_reg  <= 1'b0;
            end

            // A conflict in the same cycle as a clear survives as the first new event.
            if (clear_conflict) begin
                conflict_reg <= conflict_event;
            end else if (conflict_event) begin
                conflict_reg <= 1'b1;
            end
            conflict_count_reg <= conflict_count_next;
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_claim      = out_claim_reg;
    assign out_ext_id     = out_ext_id_reg;
    assign out_mem_to_reg = out_m2r_reg;
    assign out_rsel_s_0   = out_s0_reg;
    assign out_rsel_s_1   = out_s1_reg;
    assign out_rsel_d     = out_d_reg;
    assign out_insn       = out_insn_reg;
    assign conflict       = conflict_reg;
    assign conflict_count = conflict_count_reg;

endmodule

// File: tb/tb_risc_mgmt_decode_arbiter.sv
// Scoreboarded bench: stimulus pushes reference results, a negedge monitor pops and compares.
module tb_risc_mgmt_decode_arbiter;

    typedef struct packed {
        logic        claim;
        logic [2:0]  id;
        logic        m2r;
        logic [4:0]  s0;
        logic [4:0]  s1;
        logic [4:0]  d;
        logic [31:0] insn;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // main instance: N_EXT=4, SEL_W=5
    logic        insn_valid, insn_ready, out_valid, out_ready, out_claim, out_m2r;
    logic [31:0] insn, ext_insn, out_insn;
    logic [3:0]  ext_enable, ext_claim, ext_m2r;
    logic [19:0] rs0, rs1, rd;
    logic [1:0]  out_ext_id;
    logic [4:0]  o_s0, o_s1, o_d;
    logic        conflict, clear_conflict;
    logic [7:0]  conflict_count;

    // sweep instance A: N_EXT=1, SEL_W=4
    logic        a_valid, a_ready, a_ovalid, a_claim_o, a_m2r_o, a_conf, a_en, a_cl, a_m2r;
    logic [31:0] a_insn, a_ext_insn, a_oinsn;
    logic [3:0]  a_s0, a_s1, a_d, a_os0, a_os1, a_od;
    logic [0:0]  a_id;
    logic [7:0]  a_cnt;

    // sweep instance B: N_EXT=8, SEL_W=5
    logic        b_valid, b_ready, b_ovalid, b_claim_o, b_m2r_o, b_conf;
    logic [31:0] b_insn, b_ext_insn, b_oinsn;
    logic [7:0]  b_en, b_cl, b_m2r, b_cnt;
    logic [39:0] b_s0, b_s1, b_d;
    logic [4:0]  b_os0, b_os1, b_od;
    logic [2:0]  b_id;

    risc_mgmt_decode_arbiter #(.N_EXT(4), .SEL_W(5), .INSN_W(32), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .insn_valid(insn_valid), .insn(insn), .insn_ready(insn_ready),
        .ext_enable(ext_enable), .ext_insn(ext_insn), .ext_claim(ext_claim),
        .ext_mem_to_reg(ext_m2r), .ext_rsel_s_0(rs0), .ext_rsel_s_1(rs1), .ext_rsel_d(rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_claim(out_claim),
        .out_ext_id(out_ext_id), .out_mem_to_reg(out_m2r), .out_rsel_s_0(o_s0),
        .out_rsel_s_1(o_s1), .out_rsel_d(o_d), .out_insn(out_insn), .conflict(conflict),
        .conflict_count(conflict_count), .clear_conflict(clear_conflict));

    risc_mgmt_decode_arbiter #(.N_EXT(1), .SEL_W(4), .INSN_W(32), .CNT_W(8)) dut_a (
        .CLK(CLK), .RST(RST), .insn_valid(a_valid), .insn(a_insn), .insn_ready(a_ready),
        .ext_enable(a_en), .ext_insn(a_ext_insn), .ext_claim(a_cl),
        .ext_mem_to_reg(a_m2r), .ext_rsel_s_0(a_s0), .ext_rsel_s_1(a_s1), .ext_rsel_d(a_d),
        .out_valid(a_ovalid), .out_ready(1'b1), .out_claim(a_claim_o),
        .out_ext_id(a_id), .out_mem_to_reg(a_m2r_o), .out_rsel_s_0(a_os0),
        .out_rsel_s_1(a_os1), .out_rsel_d(a_od), .out_insn(a_oinsn), .conflict(a_conf),
        .conflict_count(a_cnt), .clear_conflict(1'b0));

    risc_mgmt_decode_arbiter #(.N_EXT(8), .SEL_W(5), .INSN_W(32), .CNT_W(8)) dut_b (
        .CLK(CLK), .RST(RST), .insn_valid(b_valid), .insn(b_insn), .insn_ready(b_ready),
        .ext_enable(b_en), .ext_insn(b_ext_insn), .ext_claim(b_cl),
        .ext_mem_to_reg(b_m2r), .ext_rsel_s_0(b_s0), .ext_rsel_s_1(b_s1), .ext_rsel_d(b_d),
        .out_valid(b_ovalid), .out_ready(1'b1), .out_claim(b_claim_o),
        .out_ext_id(b_id), .out_mem_to_reg(b_m2r_o), .out_rsel_s_0(b_os0),
        .out_rsel_s_1(b_os1), .out_rsel_d(b_od), .out_insn(b_oinsn), .conflict(b_conf),
        .conflict_count(b_cnt), .clear_conflict(1'b0));

    exp_t q0[$];
    exp_t q1[$];
    exp_t q8[$];

    logic m_full;
    logic m_conf;
    int   m_cnt;
    logic m8_conf;

    // Reference: first enabled claimant in index order supplies the fields.
    function automatic exp_t ref_model(int n, int selw, logic [7:0] cl, logic [7:0] en,
                                       logic [7:0] m2r, logic [39:0] s0, logic [39:0] s1,
                                       logic [39:0] d, logic [31:0] ins);
        exp_t e;
        logic [39:0] mask;
        e = '0;
        e.insn = ins;
        mask = (40'd1 << selw) - 40'd1;
        for (int i = 0; i < n; i++) begin
            if (cl[i] && en[i]) begin
                e.claim = 1'b1;
                e.id    = 3'(i);
                e.m2r   = m2r[i];
                e.s0    = 5'((s0 >> (i * selw)) & mask);
                e.s1    = 5'((s1 >> (i * selw)) & mask);
                e.d     = 5'((d >> (i * selw)) & mask);
                return e;
            end
        end
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    function automatic exp_t act_main();
        exp_t e;
        e = '{out_claim, {1'b0, out_ext_id}, out_m2r, o_s0, o_s1, o_d, out_insn};
        return e;
    endfunction

    function automatic exp_t act_a();
        exp_t e;
        e = '{a_claim_o, {2'b0, a_id}, a_m2r_o, {1'b0, a_os0}, {1'b0, a_os1}, {1'b0, a_od}, a_oinsn};
        return e;
    endfunction

    function automatic exp_t act_b();
        exp_t e;
        e = '{b_claim_o, b_id, b_m2r_o, b_os0, b_os1, b_od, b_oinsn};
        return e;
    endfunction

    // Monitor: a drained result is popped; a stalled one must equal the queue head.
    always @(negedge CLK) begin
        if (!RST) begin
            if (out_valid) begin
                if (q0.size() == 0) begin
                    check("main_unexpected_result", 64'(act_main()), 64'hDEAD);
                end else begin
                    check(out_ready ? "main_result" : "main_stall_hold", 64'(act_main()), 64'(q0[0]));
                    if (out_ready) void'(q0.pop_front());
                end
            end
            if (a_ovalid) begin
                if (q1.size() == 0) check("n1_unexpected_result", 64'(act_a()), 64'hDEAD);
                else check("n1_result", 64'(act_a()), 64'(q1.pop_front()));
            end
            if (b_ovalid) begin
                if (q8.size() == 0) check("n8_unexpected_result", 64'(act_b()), 64'hDEAD);
                else check("n8_result", 64'(act_b()), 64'(q8.pop_front()));
            end
        end
    end

    // One clock: status checks on the negedge, model update on the posedge.
    task automatic cycle();
        logic acc;
        int   n;
        @(negedge CLK);
        check("insn_ready", insn_ready, !m_full || out_ready);
        check("ext_insn", ext_insn, insn);
        check("conflict", conflict, m_conf);
        check("conflict_count", conflict_count, m_cnt);
        check("n1_conflict", {a_conf, a_cnt}, 9'd0);
        check("n8_conflict", b_conf, m8_conf);
        @(posedge CLK);
        acc = insn_valid && (!m_full || out_ready);
        n = $countones(ext_claim & ext_enable);
        if (acc) q0.push_back(ref_model(4, 5, {4'b0, ext_claim}, {4'b0, ext_enable},
                                        {4'b0, ext_m2r}, {20'b0, rs0}, {20'b0, rs1},
                                        {20'b0, rd}, insn));
        if (clear_conflict) begin
            m_conf = acc && (n > 1);
            m_cnt  = m_conf ? 1 : 0;
        end else if (acc && n > 1) begin
            m_conf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        if (acc) m_full = 1'b1;
        else if (out_ready) m_full = 1'b0;
        if (a_valid) q1.push_back(ref_model(1, 4, {7'b0, a_cl}, {7'b0, a_en}, {7'b0, a_m2r},
                                            {36'b0, a_s0}, {36'b0, a_s1}, {36'b0, a_d}, a_insn));
        if (b_valid) begin
            q8.push_back(ref_model(8, 5, b_cl, b_en, b_m2r, b_s0, b_s1, b_d, b_insn));
            if ($countones(b_cl & b_en) > 1) m8_conf = 1'b1;
        end
        #1;
    endtask

    task automatic rand_fields();
        ext_m2r = 4'($urandom);
        rs0 = 20'($urandom);
        rs1 = 20'($urandom);
        rd  = 20'($urandom);
        insn = $urandom;
    endtask

    task automatic drive(logic iv, logic [3:0] cl, logic [3:0] en);
        rand_fields();
        insn_valid = iv;
        ext_claim  = cl;
        ext_enable = en;
    endtask

    initial begin
        insn_valid = 0; insn = 0; ext_enable = 4'hF; ext_claim = 0; ext_m2r = 0;
        rs0 = 0; rs1 = 0; rd = 0; out_ready = 1; clear_conflict = 0;
        a_valid = 0; a_insn = 0; a_en = 0; a_cl = 0; a_m2r = 0; a_s0 = 0; a_s1 = 0; a_d = 0;
        b_valid = 0; b_insn = 0; b_en = 0; b_cl = 0; b_m2r = 0; b_s0 = 0; b_s1 = 0; b_d = 0;
        m_full = 0; m_conf = 0; m_cnt = 0; m8_conf = 0;

        #3;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_insn_ready", insn_ready, 1'b1);
        check("reset_conflict", {conflict, conflict_count}, 9'd0);
        check("reset_out_fields", 64'(act_main()), 64'd0);
        @(posedge CLK);
        #3 RST = 0;

        // no claims: core handles the instruction
        insn_valid = 1; insn = 32'h0000_000B; ext_claim = 0; ext_enable = 4'hF;
        cycle();
        // single claim from ext 2
        insn_valid = 1; insn = 32'h1234_5678; ext_claim = 4'b0100; ext_enable = 4'hF;
        ext_m2r = 4'b0100; rs0 = 20'(5'd3) << 10; rd = 20'(5'd7) << 10; rs1 = 20'(5'd9) << 10;
        cycle();
        // conflicts, saturation, clear coincident with conflict, plain clear
        drive(1, 4'b1010, 4'hF);
        cycle();
        for (int i = 0; i < 300; i++) begin
            drive(1, 4'b1010, 4'hF);
            cycle();
        end
        drive(1, 4'b1111, 4'hF); clear_conflict = 1;
        cycle();
        drive(0, 4'b0000, 4'hF);
        cycle();
        clear_conflict = 0;
        // enable mask
        drive(1, 4'b0011, 4'b1110);
        cycle();
        drive(1, 4'b0001, 4'b1110);
        cycle();
        // backpressure: 3 stall cycles then drain+load with no bubble
        drive(1, 4'b0010, 4'hF);
        cycle();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'($urandom), 4'hF);
            cycle();
        end
        out_ready = 1;
        drive(1, 4'b1000, 4'hF);
        cycle();
        for (int i = 0; i < 10; i++) begin
            drive(1, 4'($urandom), 4'($urandom));
            insn = 32'hA000_0000 + 32'(i);
            cycle();
        end
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom | $urandom));
            out_ready = $urandom_range(0, 3) != 0;
            clear_conflict = $urandom_range(0, 31) == 0;
            cycle();
        end
        clear_conflict = 0; out_ready = 1; insn_valid = 0;
        cycle();

        // parameter sweep: N_EXT=1/SEL_W=4 and N_EXT=8
        for (int i = 0; i < 12; i++) begin
            a_valid = 1; a_insn = $urandom; a_m2r = 1'($urandom);
            a_s0 = 4'($urandom); a_s1 = 4'($urandom); a_d = 4'($urandom);
            a_cl = 1'(i); a_en = (i % 4) != 3;
            b_valid = 1; b_insn = $urandom; b_m2r = 8'($urandom);
            b_s0 = {$urandom, 8'($urandom)}; b_s1 = {$urandom, 8'($urandom)};
            b_d = {$urandom, 8'($urandom)};
            b_en = 8'hFF;
            if (i < 8) b_cl = 8'(1 << i);
            else if (i == 8) b_cl = 8'hFF;
            else if (i == 9) begin b_cl = 8'hFF; b_en = 8'h80; end
            else b_cl = 8'($urandom);
            cycle();
        end
        a_valid = 0; b_valid = 0;
        cycle();

        // reset while a result is stalled
        out_ready = 0;
        drive(1, 4'b0110, 4'hF);
        cycle();
        insn_valid = 0;
        cycle();
        #1 RST = 1;
        #1;
        check("midstall_reset_out_valid", out_valid, 1'b0);
        check("midstall_reset_insn_ready", insn_ready, 1'b1);
        check("midstall_reset_fields", 64'(act_main()), 64'd0);
        check("midstall_reset_conflict", {conflict, conflict_count}, 9'd0);
        q0.delete(); q1.delete(); q8.delete();
        m_full = 0; m_conf = 0; m_cnt = 0; m8_conf = 0;
        @(posedge CLK);
        #3 RST = 0;
        out_ready = 1;
        drive(1, 4'b0001, 4'hF);
        cycle();
        insn_valid = 0;
        cycle();
        cycle();
        check("main_queue_drained", q0.size(), 0);
        check("n1_queue_drained", q1.size(), 0);
        check("n8_queue_drained", q8.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
